node_inject_queue: RTL and testbench
====================================

Name: node_inject_queue

Overview:
- Injection stage directly upstream of the node router's local input port (port 4).
- Accepts payload words plus a destination {y,x} address from the local neuron/compute element and formats them into router stream words: destination header in the top NET_WIDTH bits, then source address, sequence tag, payload.
- Buffers the formatted words in a first-word-fall-through FIFO and presents the head word to the router with a valid/ready handshake.
- Decouples neuron issue rate from router arbitration stalls.

Parameters:
- STREAM_WIDTH, 144: router stream word width.
- NET_WIDTH, 4: node address width, {y,x}.
- NW_HALF, 2: width of each of the x and y fields. NET_WIDTH = 2*NW_HALF.
- SEQ_WIDTH, 8: per-node sequence tag width.
- PAYLOAD_WIDTH, STREAM_WIDTH-2*NET_WIDTH-SEQ_WIDTH (128): payload bits.
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- SELF_X, 0: this node's x coordinate.
- SELF_Y, 0: this node's y coordinate.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  1  producer has a word to inject.
- push_ready  out  1  queue can accept a word this cycle.
- push_dst  in  NET_WIDTH  destination address: {y[NW_HALF-1:0], x[NW_HALF-1:0]}.
- push_data  in  PAYLOAD_WIDTH  payload.
- out_valid  out  1  out_stream holds a valid word.
- out_ready  in  1  router consumed the word this cycle.
- out_stream  out  STREAM_WIDTH  formatted word to the router local input.
- level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- seq_next  out  SEQ_WIDTH  tag that the next accepted push will carry.

Behaviour:
- Word format, built at push time:
  - [STREAM_WIDTH-1 -: NET_WIDTH] = push_dst
  - next NET_WIDTH bits = {SELF_Y, SELF_X}, each truncated to NW_HALF bits
  - next SEQ_WIDTH bits = seq_next
  - low PAYLOAD_WIDTH bits = push_data
- Reset (rst_n low, asynchronous, any cycle):
  - write pointer, read pointer, count and seq cleared to 0.
  - Outputs: out_valid=0, out_stream=0, level=0, seq_next=0, push_ready=1.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all queued words. The first word after reset carries seq 0.
- Push accepted: push_valid && push_ready at a rising edge.
  - Word written at wr_ptr; wr_ptr increments modulo DEPTH.
  - seq increments, wrapping 2^SEQ_WIDTH-1 -> 0.
- Pop: out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- push_ready = (count != DEPTH). Combinational from registered count only; it never depends on out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0).
  - out_stream = mem[rd_ptr] when valid, otherwise all zeros. A zero word must never carry stale data.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop (legal whenever 0 < count < DEPTH).
  - Push into an empty queue with out_ready=1 is not a pop that cycle, because out_valid=0. The word appears next cycle.
- Latency: a word accepted at edge N is visible with out_valid=1 in the cycle after edge N, i.e. 1 cycle of fall-through.
- Ordering: strict FIFO. Once out_valid is high, out_stream is held stable until popped.
- out_ready while out_valid=0: ignored, no pointer movement.
- Destination equal to self ({SELF_Y,SELF_X}): formatted and sent unchanged. The router handles local delivery.
- level = count. seq_next = seq register.

Test Plan:
- Reset then single push (SELF_X=1, SELF_Y=2, dst=4'b1011, data=128'hA5, out_ready=0):
  - next cycle out_valid=1, out_stream[143:140]=4'hB, [139:136]=4'h9, [135:128]=8'h00, [127:0]=128'hA5.
  - level=1, seq_next=1.
- Fill to DEPTH=4 with out_ready=0:
  - push_ready drops after the 4th accept, level=4.
  - A 5th push held for 3 cycles is not accepted; seq_next stays 4.
- Full with push_valid=1 and out_ready=1:
  - cycle 1: pop only, level 4->3.
  - cycle 2: push_ready=1, simultaneous push and pop, level stays 3.
  - Words emerge in order with seq 0,1,2,3,4.
- Router backpressure (out_ready toggles 1,0,0,1 on a queue of 2 words):
  - out_stream is stable while out_ready=0.
  - Exactly 2 pops, then out_valid=0 and out_stream=0.
- 256 back-to-back pushes with out_ready=1:
  - seq runs 0..255 then wraps to 0; no word is lost or reordered.
- Assert rst_n=0 asynchronously mid-edge with level=3:
  - out_valid, level, out_stream and seq_next go to 0 immediately without a clock edge.
  - After release, the first push carries seq 0.

Source files
------------

// File: rtl/node_inject_queue.sv
// Local-port injection queue: formats neuron pushes into router stream words
// and buffers them in a first-word-fall-through FIFO ahead of router port 4.
module node_inject_queue #(
    parameter int STREAM_WIDTH  = 144,
    parameter int NET_WIDTH     = 4,
    parameter int NW_HALF       = 2,
    parameter int SEQ_WIDTH     = 8,
    parameter int PAYLOAD_WIDTH = STREAM_WIDTH - 2*NET_WIDTH - SEQ_WIDTH,
    parameter int DEPTH         = 4,
    parameter int SELF_X        = 0,
    parameter int SELF_Y        = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [NET_WIDTH-1:0]     push_dst,
    input  logic [PAYLOAD_WIDTH-1:0] push_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [STREAM_WIDTH-1:0]  out_stream,
    output logic [$clog2(DEPTH):0]   level,
    output logic [SEQ_WIDTH-1:0]     seq_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [NW_HALF-1:0] SX = NW_HALF'(SELF_X);
    localparam logic [NW_HALF-1:0] SY = NW_HALF'(SELF_Y);

    logic [STREAM_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           count;
    logic [SEQ_WIDTH-1:0]    seq;
    logic                    push_fire;
    logic                    pop_fire;
    logic [STREAM_WIDTH-1:0] word;

    // Ready looks only at registered occupancy, so a full queue refuses
    // a push even when the router drains a word in the same cycle.
    assign push_ready = (count != LW'(DEPTH));
    assign out_valid  = (count != '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = out_valid && out_ready;

    assign word = {push_dst, SY, SX, seq, push_data};

    assign out_stream = out_valid ? mem[rd_ptr] : '0;
    assign level      = count;
    assign seq_next   = seq;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + SEQ_WIDTH'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_node_inject_queue.sv
// Bench for node_inject_queue: vector table for fill/stall/full-drain plus
// hand sequences for format, backpressure, seq wrap and async reset.
module tb_node_inject_queue;

    logic         clk;
    logic         rst_n;
    logic         push_valid;
    logic         push_ready;
    logic [3:0]   push_dst;
    logic [127:0] push_data;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] out_stream;
    logic [2:0]   level;
    logic [7:0]   seq_next;

    int n_cmp;
    int n_bad;

    logic [143:0] sb_q[$];
    int           m_count;
    logic [7:0]   m_seq;

    typedef struct {
        logic       pv;
        logic       orr;
        logic [3:0] dst;
        logic       exp_ready;
        logic       exp_valid;
        logic [2:0] exp_level;
        logic [7:0] exp_seq;
    } vec_t;

    vec_t tbl [13];

    node_inject_queue #(
        .SELF_X(1),
        .SELF_Y(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_dst   (push_dst),
        .push_data  (push_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_stream (out_stream),
        .level      (level),
        .seq_next   (seq_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [143:0] act,
                         input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, out_valid, 1'b0);
        check({name, "_stream"}, out_stream, '0);
        check({name, "_level"}, level, 3'd0);
    endtask

    // One clock: drive at negedge, score just before the rising edge.
    task automatic cycle(input logic pv, input logic orr,
                         input logic [3:0] dst, input logic [127:0] data);
        logic acc;
        logic pop;
        logic [143:0] exp_w;
        push_valid = pv;
        out_ready  = orr;
        push_dst   = dst;
        push_data  = data;
        #1;
        acc = pv && (m_count != 4);
        pop = orr && (m_count != 0);
        if (acc) sb_q.push_back({dst, 4'h9, m_seq, data});
        if (pop) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got pop expected none");
            end else begin
                exp_w = sb_q.pop_front();
                check("fifo_word", out_stream, exp_w);
            end
        end
        @(posedge clk);
        if (acc) m_seq = m_seq + 8'd1;
        m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        out_ready  = 1'b0;
        push_dst   = '0;
        push_data  = '0;
        rst_n      = 1'b0;
        sb_q.delete();
        m_count = 0;
        m_seq   = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Fill, held 5th push, full pop-then-push, drain.
        tbl[0]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 3'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 3'd1, 8'd1};
        tbl[2]  = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 3'd2, 8'd2};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 3'd3, 8'd3};
        tbl[4]  = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b1, 3'd4, 8'd4};
        tbl[5]  = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b1, 3'd4, 8'd4};
        tbl[6]  = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b1, 3'd4, 8'd4};
        tbl[7]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 3'd4, 8'd4};
        tbl[8]  = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b1, 3'd3, 8'd4};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd3, 8'd5};
        tbl[10] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd2, 8'd5};
        tbl[11] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd1, 8'd5};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 8'd5};

        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        check_idle("rst");
        check("rst_seq", seq_next, 8'd0);
        check("rst_ready", push_ready, 1'b1);

        // Single push: format and 1-cycle fall-through.
        cycle(1'b1, 1'b0, 4'b1011, 128'hA5);
        #1;
        check("fmt_valid", out_valid, 1'b1);
        check("fmt_dst", out_stream[143:140], 4'hB);
        check("fmt_src", out_stream[139:136], 4'h9);
        check("fmt_seq", out_stream[135:128], 8'h00);
        check("fmt_data", out_stream[127:0], 128'hA5);
        check("fmt_level", level, 3'd1);
        check("fmt_seq_next", seq_next, 8'd1);
        cycle(1'b0, 1'b1, 4'h0, '0);
        #1;
        check_idle("fmt_drain");

        do_reset();
        for (int i = 0; i < 13; i++) begin
            push_valid = tbl[i].pv;
            out_ready  = tbl[i].orr;
            push_dst   = tbl[i].dst;
            push_data  = 128'h1000 + 128'(i);
            #1;
            check($sformatf("vec%0d_ready", i), push_ready, tbl[i].exp_ready);
            check($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
            check($sformatf("vec%0d_level", i), level, tbl[i].exp_level);
            check($sformatf("vec%0d_seq", i), seq_next, tbl[i].exp_seq);
            cycle(tbl[i].pv, tbl[i].orr, tbl[i].dst, 128'h1000 + 128'(i));
        end
        check("vec_sb_empty", 144'(sb_q.size()), 144'd0);

        // Backpressure: out_ready 1,0,0,1 over two queued words.
        do_reset();
        cycle(1'b1, 1'b0, 4'h3, 128'hBEEF0);
        cycle(1'b1, 1'b0, 4'h4, 128'hBEEF1);
        cycle(1'b0, 1'b1, 4'h0, '0);
        cycle(1'b0, 1'b0, 4'h0, '0);
        #1;
        check("bp_hold1", out_stream, {4'h4, 4'h9, 8'd1, 128'hBEEF1});
        cycle(1'b0, 1'b0, 4'h0, '0);
        #1;
        check("bp_hold2", out_stream, {4'h4, 4'h9, 8'd1, 128'hBEEF1});
        cycle(1'b0, 1'b1, 4'h0, '0);
        #1;
        check_idle("bp_end");

        // 256 back-to-back pushes with the router always ready.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b1, 4'(i), 128'(i * 7 + 3));
        end
        #1;
        check("wrap_seq", seq_next, 8'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 4'h0, '0);
        end
        #1;
        check("wrap_sb_empty", 144'(sb_q.size()), 144'd0);
        check_idle("wrap_end");

        // Asynchronous reset between edges with three words queued.
        do_reset();
        cycle(1'b1, 1'b0, 4'h1, 128'h11);
        cycle(1'b1, 1'b0, 4'h2, 128'h22);
        cycle(1'b1, 1'b0, 4'h3, 128'h33);
        push_valid = 1'b0;
        @(posedge clk);
        #2;
        check("arst_pre_level", level, 3'd3);
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        check("arst_seq", seq_next, 8'd0);
        check("arst_ready", push_ready, 1'b1);
        sb_q.delete();
        m_count = 0;
        m_seq   = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 4'h9, 128'h77);
        #1;
        check("arst_first", out_stream, {4'h9, 4'h9, 8'h00, 128'h77});
        cycle(1'b0, 1'b1, 4'h0, '0);
        #1;
        check_idle("arst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
